// File: rtl/inv_addkey_mixcol.sv
// inv_addkey_mixcol: AES decryption round tail. Registers (state ^ round_key),
// then applies InvMixColumns COLS_PER_CYCLE columns per clock unless the
// operation is a final round, and holds the result until downstream takes it.
module inv_addkey_mixcol #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned NCOL     = COLS_PER_CYCLE;
    localparam logic [1:0]  STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0]  LAST_COL = 2'(4 - COLS_PER_CYCLE);

    state_t        state;
    state_t        state_nxt;
    logic [127:0]  s;
    logic [127:0]  s_mixed;
    logic [1:0]    col;
    logic          lr_q;
    logic          accept;
    logic          last_grp;

    // GF(2^8) doubling with reduction by 0x11B
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns of one column, a0 in the most significant byte
    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a   [4];
        logic [7:0] m9  [4];
        logic [7:0] mb  [4];
        logic [7:0] md  [4];
        logic [7:0] me  [4];
        logic [7:0] x2, x4, x8;
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = c[31 - 8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign accept    = in_valid && (state == IDLE);
    assign last_grp  = (col == LAST_COL);
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == HOLD);
    assign out_state = s;

    // Mix the COLS_PER_CYCLE columns starting at the column counter
    always_comb begin
        logic [1:0] c;
        s_mixed = s;
        for (int unsigned i = 0; i < NCOL; i++) begin
            c = col + 2'(i);
            s_mixed[127 - 32*int'(c) -: 32] = inv_mix(s[127 - 32*int'(c) -: 32]);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = last_round ? HOLD : MIX;
            // lr_q is a guard only: final rounds bypass MIX entirely
            MIX:  if (last_grp || lr_q) state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, update columns while mixing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            col  <= '0;
            lr_q <= 1'b0;
        end else if (accept) begin
            s    <= in_state ^ round_key;
            col  <= '0;
            lr_q <= last_round;
        end else if (state == MIX) begin
            s <= s_mixed;
            // counter parks on the last group instead of wrapping
            if (!last_grp) col <= col + STEP;
        end
    end

endmodule

// File: tb/tb_inv_addkey_mixcol.sv
// tb_inv_addkey_mixcol: directed checks for inv_addkey_mixcol with three
// instances (1, 2 and 4 columns per cycle) sharing clock, reset and data.
module tb_inv_addkey_mixcol;

    logic         clk;
    logic         rst_n;
    logic [2:0]   in_valid_v;
    logic [2:0]   in_ready_v;
    logic [127:0] in_state;
    logic [127:0] round_key;
    logic         last_round;
    logic [2:0]   out_valid_v;
    logic         out_ready;
    logic [127:0] out_state_v [3];
    logic [2:0]   busy_v;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KAT_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] KAT_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

    inv_addkey_mixcol #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_state(in_state), .round_key(round_key), .last_round(last_round),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_state(out_state_v[0]),
        .busy(busy_v[0])
    );

    inv_addkey_mixcol #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_state(in_state), .round_key(round_key), .last_round(last_round),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_state(out_state_v[1]),
        .busy(busy_v[1])
    );

    inv_addkey_mixcol #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_state(in_state), .round_key(round_key), .last_round(last_round),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_state(out_state_v[2]),
        .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one state to instance k, take the accept edge, scramble the
    // inputs, then count further edges until out_valid (-1 on timeout).
    // A final round reaches HOLD on the accept edge itself, so lat is 0 there.
    task automatic accept_and_wait(input int k, input logic [127:0] st,
                                   input logic [127:0] key, input logic lr,
                                   output int lat);
        in_state      = st;
        round_key     = key;
        last_round    = lr;
        in_valid_v[k] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0;
        in_state      = ~st;
        round_key     = st ^ 128'h5a5a;
        last_round    = ~lr;
        lat = 0;
        while (!out_valid_v[k] && lat <= 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid_v[k]) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1 || busy_v[k] !== 1'b0
                || out_state_v[k] !== '0) begin
                errors++;
                $display("FAIL reset[%0d]: got valid=%b ready=%b busy=%b out=%h, want 0 1 0 0",
                         k, out_valid_v[k], in_ready_v[k], busy_v[k], out_state_v[k]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_kat(input int k, input int exp_lat);
        int lat;
        checks++;
        if (in_ready_v[k] !== 1'b1) begin
            errors++;
            $display("FAIL kat%0d_ready: got %b want 1", k, in_ready_v[k]);
        end
        accept_and_wait(k, KAT_IN, '0, 1'b0, lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL kat%0d_latency: got %0d want %0d", k, lat, exp_lat);
        end
        checks++;
        if (out_state_v[k] !== KAT_OUT) begin
            errors++;
            $display("FAIL kat%0d_data: got %h want %h", k, out_state_v[k], KAT_OUT);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1) begin
            errors++;
            $display("FAIL kat%0d_release: got valid=%b ready=%b want 0 1",
                     k, out_valid_v[k], in_ready_v[k]);
        end
    endtask

    task automatic test_final_round();
        int lat;
        accept_and_wait(0, 128'h00112233445566778899aabbccddeeff,
                        128'h000102030405060708090a0b0c0d0e0f, 1'b1, lat);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL final_latency: got %0d extra edges want 0", lat);
        end
        checks++;
        if (out_state_v[0] !== 128'h00102030405060708090a0b0c0d0e0f0) begin
            errors++;
            $display("FAIL final_data: got %h want %h", out_state_v[0],
                     128'h00102030405060708090a0b0c0d0e0f0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_key_cancel();
        int lat;
        logic [127:0] r;
        for (int k = 0; k < 3; k += 2) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            accept_and_wait(k, r, r, 1'b0, lat);
            checks++;
            if (lat < 0 || out_state_v[k] !== '0) begin
                errors++;
                $display("FAIL key_cancel%0d: got lat=%0d out=%h want 0", k, lat, out_state_v[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int edge_n = 0;
        int acc0   = -1;
        int acc1   = -1;
        logic pre_ready;
        logic [127:0] b_in  = 128'h01010101_c6c6c6c6_8e4da1bc_9fdc589d;
        logic [127:0] b_out = 128'h01010101_c6c6c6c6_db135345_f20a225c;
        in_state = KAT_IN; round_key = '0; last_round = 1'b0;
        in_valid_v[0] = 1'b1;
        while (acc1 < 0 && edge_n < 40) begin
            pre_ready = in_ready_v[0];
            @(posedge clk); #1;
            edge_n++;
            if (out_valid_v[0] && acc1 < 0) begin
                checks++;
                if (out_state_v[0] !== KAT_OUT) begin
                    errors++;
                    $display("FAIL b2b_first: got %h want %h", out_state_v[0], KAT_OUT);
                end
            end
            if (pre_ready) begin
                if (acc0 < 0) begin
                    acc0 = edge_n;
                    in_state = b_in;
                end else begin
                    acc1 = edge_n;
                end
            end
        end
        in_valid_v[0] = 1'b0;
        checks++;
        if (acc0 < 0 || acc1 < 0 || (acc1 - acc0) !== 6) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want 6", acc1 - acc0);
        end
        for (int n = 0; n < 20 && !out_valid_v[0]; n++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid_v[0] !== 1'b1 || out_state_v[0] !== b_out) begin
            errors++;
            $display("FAIL b2b_second: got valid=%b out=%h want 1 %h",
                     out_valid_v[0], out_state_v[0], b_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        accept_and_wait(0, KAT_IN, '0, 1'b0, lat);
        for (int n = 0; n < 10; n++) begin
            in_valid_v[0] = n[0];
            in_state      = {4{$urandom}};
            checks++;
            if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || out_state_v[0] !== KAT_OUT) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b out=%h want 1 0 %h",
                         n, out_valid_v[0], in_ready_v[0], out_state_v[0], KAT_OUT);
            end
            @(posedge clk); #1;
        end
        in_valid_v[0] = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_handshake: got valid=%b ready=%b want 0 1", out_valid_v[0], in_ready_v[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_v[0] !== 1'b0 || out_valid_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_extra: got busy=%b valid=%b want 0 0", busy_v[0], out_valid_v[0]);
        end
    endtask

    task automatic test_reset_mid();
        in_state = KAT_IN; round_key = '0; last_round = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_busy: got busy=%b valid=%b want 1 0", busy_v[0], out_valid_v[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_v[0] !== 1'b0 || out_state_v[0] !== '0 || in_ready_v[0] !== 1'b1
            || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got valid=%b out=%h ready=%b busy=%b want 0 0 1 0",
                     out_valid_v[0], out_state_v[0], in_ready_v[0], busy_v[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_kat(0, 4);
    endtask

    initial begin
        in_valid_v = '0;
        in_state   = '0;
        round_key  = '0;
        last_round = 1'b0;
        out_ready  = 1'b1;
        test_reset();
        test_kat(0, 4);
        test_kat(1, 2);
        test_kat(2, 1);
        test_final_round();
        test_key_cancel();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
